// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared ALU operator, RV32B and issue-state types plus operator cycle count
package ibex_pkg;

  typedef enum integer {
    RV32BNone,
    RV32BBalanced,
    RV32BOTEarlGrey,
    RV32BFull
  } rv32b_e;

  typedef enum logic [6:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_ROR,
    ALU_ROL,
    ALU_CMIX,
    ALU_CMOV,
    ALU_FSL,
    ALU_FSR
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } issue_state_e;

  // Ternary and rotate operators need a second pass through the ALU when bitmanip is present.
  function automatic logic [1:0] alu_op_cycles(alu_op_e op, rv32b_e rv32b);
    logic [1:0] n;
    n = 2'd1;
    if (rv32b != RV32BNone) begin
      case (op)
        ALU_CMOV, ALU_CMIX, ALU_FSL, ALU_FSR, ALU_ROL, ALU_ROR: n = 2'd2;
        default: n = 2'd1;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/ibex_alu_issue.sv
// rtl/ibex_alu_issue.sv - issue/response wrapper sequencing single- and multi-cycle ALU operations
module ibex_alu_issue
  import ibex_pkg::*;
#(
  parameter rv32b_e RV32B = RV32BNone
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  alu_op_e          req_op_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic             flush_i,
  output alu_op_e          alu_operator_o,
  output logic [31:0]      alu_operand_a_o,
  output logic [31:0]      alu_operand_b_o,
  output logic             alu_instr_first_cycle_o,
  output logic [1:0][31:0] alu_imd_val_q_o,
  input  logic [1:0]       alu_imd_val_we_i,
  input  logic [1:0][31:0] alu_imd_val_d_i,
  input  logic [31:0]      alu_result_i,
  input  logic             alu_cmp_result_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic             rsp_cmp_o,
  output logic             busy_o
);

  issue_state_e state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [1:0]   len_q, len_d;
  logic         accept;
  logic         capture;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    capture = 1'b0;

    req_ready_o = !flush_i && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_i));
    accept      = req_valid_i && req_ready_o;

    case (state_q)
      EXEC: begin
        if (cnt_q == len_q - 2'd1) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance in RESP overrides the return to IDLE, giving a bubble-free hand-off.
    if (accept) begin
      state_d = EXEC;
      cnt_d   = 2'd0;
      len_d   = alu_op_cycles(req_op_i, RV32B);
    end

    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
      capture = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      len_q   <= 2'd1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_operator_o  <= ALU_ADD;
      alu_operand_a_o <= 32'd0;
      alu_operand_b_o <= 32'd0;
      rsp_result_o    <= 32'd0;
      rsp_cmp_o       <= 1'b0;
      alu_imd_val_q_o <= '0;
    end else begin
      if (accept) begin
        alu_operator_o  <= req_op_i;
        alu_operand_a_o <= req_a_i;
        alu_operand_b_o <= req_b_i;
      end
      if (capture) begin
        rsp_result_o <= alu_result_i;
        rsp_cmp_o    <= alu_cmp_result_i;
      end
      // Intermediate writes only count while an operation is executing and not being aborted.
      if ((state_q == EXEC) && !flush_i) begin
        for (int i = 0; i < 2; i++) begin
          if (alu_imd_val_we_i[i]) alu_imd_val_q_o[i] <= alu_imd_val_d_i[i];
        end
      end
    end
  end

  assign alu_instr_first_cycle_o = (state_q == EXEC) && (cnt_q == 2'd0);
  assign rsp_valid_o             = (state_q == RESP);
  assign busy_o                  = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_alu_issue.sv
// tb/tb_ibex_alu_issue.sv - scoreboard bench for ibex_alu_issue with a behavioural ALU
module tb_ibex_alu_issue;
  import ibex_pkg::*;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  alu_op_e          req_op;
  logic [31:0]      req_a, req_b;
  logic             flush;
  alu_op_e          alu_op;
  logic [31:0]      alu_a, alu_b;
  logic             first_cycle;
  logic [1:0][31:0] imd_q;
  logic [1:0]       imd_we;
  logic [1:0][31:0] imd_d;
  logic [31:0]      alu_res;
  logic             alu_cmp;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_cmp;
  logic             busy;

  logic [1:0]       force_we;
  logic [1:0][31:0] force_d;

  ibex_alu_issue #(.RV32B(RV32BFull)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
    .flush_i(flush),
    .alu_operator_o(alu_op), .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
    .alu_instr_first_cycle_o(first_cycle),
    .alu_imd_val_q_o(imd_q), .alu_imd_val_we_i(imd_we), .alu_imd_val_d_i(imd_d),
    .alu_result_i(alu_res), .alu_cmp_result_i(alu_cmp),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_cmp_o(rsp_cmp),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: CMOV stages a+1 and b in the imd registers, then xors them.
  always_comb begin
    alu_res = 32'd0;
    alu_cmp = 1'b0;
    imd_we  = force_we;
    imd_d   = force_d;
    case (alu_op)
      ALU_ADD: alu_res = alu_a + alu_b;
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_SLT: begin
        alu_cmp = $signed(alu_a) < $signed(alu_b);
        alu_res = {31'd0, alu_cmp};
      end
      ALU_CMOV: begin
        if (first_cycle) begin
          imd_we   = 2'b11;
          imd_d[0] = alu_a + 32'd1;
          imd_d[1] = alu_b;
        end else begin
          alu_res = imd_q[0] ^ imd_q[1];
        end
      end
      default: alu_res = 32'd0;
    endcase
  end

  typedef struct {
    logic [31:0] r;
    logic        c;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   rsp_cyc_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   fc_cnt = 0;
  int   exec_cnt = 0;
  bit   in_rsp = 0;
  logic [31:0] hold_r;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) acc_q.push_back(cyc);
    if (rst_n && first_cycle) fc_cnt++;
    if (rst_n && busy && !rsp_valid) exec_cnt++;
  end

  // Monitor: checks each new response against the scoreboard and its stability while stalled.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (!in_rsp) begin
        in_rsp = 1;
        hold_r = rsp_result;
        rsp_cyc_q.push_back(cyc);
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_rsp actual=%h required=none", rsp_result);
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("rsp_result", rsp_result, e.r);
          chk("rsp_cmp", {31'd0, rsp_cmp}, {31'd0, e.c});
          chk("rsp_latency", cyc - a, e.lat);
        end
      end else begin
        chk("rsp_stable", rsp_result, hold_r);
      end
      if (rsp_ready) in_rsp = 0;
    end else begin
      in_rsp = 0;
    end
  end

  task automatic issue(alu_op_e op, logic [31:0] a, logic [31:0] b,
                       logic [31:0] er, logic ec, int lat, bit push);
    bit ok;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    if (push) exp_q.push_back('{r: er, c: ec, lat: lat});
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    errors++;
    checks++;
    $display("FAIL idle_timeout actual=busy required=idle");
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    chk({tag, "_rsp_cmp"}, {31'd0, rsp_cmp}, 32'd0);
    chk({tag, "_first_cycle"}, {31'd0, first_cycle}, 32'd0);
    chk({tag, "_op_a"}, alu_a, 32'd0);
    chk({tag, "_op_b"}, alu_b, 32'd0);
    chk({tag, "_imd0"}, imd_q[0], 32'd0);
    chk({tag, "_imd1"}, imd_q[1], 32'd0);
    chk({tag, "_operator"}, {25'd0, alu_op}, {25'd0, ALU_ADD});
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = ALU_ADD;
    req_a = 32'd0;
    req_b = 32'd0;
    flush = 1'b0;
    rsp_ready = 1'b1;
    force_we = 2'b00;
    force_d = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle AND
    fc_cnt = 0; exec_cnt = 0;
    issue(ALU_AND, 32'hFFFF_FF00, 32'h00FF_FFFF, 32'h00FF_FF00, 1'b0, 2, 1);
    wait_idle();
    chk("and_first_cycles", fc_cnt, 32'd1);
    chk("and_exec_cycles", exec_cnt, 32'd1);

    // Two-cycle CMOV through the imd registers
    fc_cnt = 0; exec_cnt = 0;
    issue(ALU_CMOV, 32'h0000_0010, 32'h0000_000F, 32'h0000_001E, 1'b0, 3, 1);
    wait_idle();
    chk("cmov_first_cycles", fc_cnt, 32'd1);
    chk("cmov_exec_cycles", exec_cnt, 32'd2);
    chk("cmov_imd0", imd_q[0], 32'h0000_0011);
    chk("cmov_imd1", imd_q[1], 32'h0000_000F);

    // imd writes while idle are ignored
    @(posedge clk); #1;
    force_we = 2'b11;
    @(posedge clk); #1;
    force_we = 2'b00;
    chk("idle_we_imd0", imd_q[0], 32'h0000_0011);
    chk("idle_we_imd1", imd_q[1], 32'h0000_000F);
    chk("idle_operand_a", alu_a, 32'h0000_0010);

    // Stalled response
    rsp_ready = 1'b0;
    issue(ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 2, 1);
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_result", rsp_result, 32'h00F0_00F0);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_idle();
    chk("no_clear_imd0", imd_q[0], 32'h0000_0011);

    // Signed compare result
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 2, 1);
    wait_idle();

    // Back-to-back hand-off
    issue(ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 2, 1);
    issue(ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 2, 1);
    wait_idle();
    if (rsp_cyc_q.size() >= 2)
      chk("b2b_spacing", rsp_cyc_q[rsp_cyc_q.size()-1] - rsp_cyc_q[rsp_cyc_q.size()-2], 32'd2);

    // Flush in the second cycle of CMOV, with a concurrent imd write attempt
    issue(ALU_CMOV, 32'h0000_0020, 32'h0000_0030, 32'd0, 1'b0, 3, 0);
    @(posedge clk); #1;
    flush = 1'b1;
    force_we = 2'b11;
    chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    force_we = 2'b00;
    if (acc_q.size() > 0) void'(acc_q.pop_back());
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_imd0", imd_q[0], 32'h0000_0021);
    chk("flush_imd1", imd_q[1], 32'h0000_0030);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    // Asynchronous reset mid-EXEC
    issue(ALU_CMOV, 32'h0000_0040, 32'h0000_0050, 32'd0, 1'b0, 3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    if (acc_q.size() > 0) void'(acc_q.pop_back());
    @(negedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    chk("cycles_none_cmov", {30'd0, alu_op_cycles(ALU_CMOV, RV32BNone)}, 32'd1);
    chk("cycles_full_ror", {30'd0, alu_op_cycles(ALU_ROR, RV32BFull)}, 32'd2);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibex_alu_issue.md
IBEX_ALU_ISSUE -- requirements
Module: ibex_alu_issue

Interface
REQ-001 SHALL have parameter RV32B, ibex_pkg::rv32b_e, default ibex_pkg::RV32BNone; when RV32BNone, every operation SHALL be single-cycle.
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port clk_i  in  1  clock; all state updates on its rising edge.
REQ-004 Port rst_ni  in  1  asynchronous, active-low reset.
REQ-005 Port req_valid_i  in  1  request valid.
REQ-006 Port req_ready_o  out  1  request accepted when valid & ready.
REQ-007 Port req_op_i  in  ibex_pkg::alu_op_e  requested operator.
REQ-008 Port req_a_i, req_b_i  in  32 each  operands.
REQ-009 Port flush_i  in  1  synchronous abort.
REQ-010 Port alu_operator_o  out  alu_op_e, plus alu_operand_a_o and alu_operand_b_o  out  32 each  latched request, to the ALU.
REQ-011 Port alu_instr_first_cycle_o  out  1  first execute cycle of the current operation.
REQ-012 Port alu_imd_val_q_o  out  2x32  intermediate value registers, to the ALU.
REQ-013 Port alu_imd_val_we_i  in  2; port alu_imd_val_d_i  in  2x32; both from the ALU.
REQ-014 Port alu_result_i  in  32; port alu_cmp_result_i  in  1; both from the ALU.
REQ-015 Port rsp_valid_o  out  1; port rsp_ready_i  in  1; port rsp_result_o  out  32; port rsp_cmp_o  out  1.
REQ-016 Port busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-018 req_ready_o SHALL be high in IDLE, and in RESP when rsp_ready_i is high; it SHALL be low whenever flush_i is high.
REQ-019 On accept, SHALL latch op, a and b into the ALU outputs, load the cycle length N from ibex_pkg, clear the counter and enter EXEC.
REQ-020 N SHALL be 2 for ALU_CMOV, ALU_CMIX, ALU_FSL, ALU_FSR, ALU_ROL and ALU_ROR when RV32B != RV32BNone, and 1 otherwise.
REQ-021 In EXEC, alu_instr_first_cycle_o SHALL be 1 when count == 0, and 0 otherwise.
REQ-022 In EXEC, SHALL write imd register i from alu_imd_val_d_i[i] when alu_imd_val_we_i[i] is high, per index independently.
REQ-023 Writes enabled by alu_imd_val_we_i outside EXEC SHALL be ignored.
REQ-024 The imd registers SHALL otherwise hold their value and SHALL NOT clear on accept.
REQ-025 In the EXEC cycle where count == N-1, SHALL register alu_result_i and alu_cmp_result_i into rsp_result_o and rsp_cmp_o, then enter RESP.
REQ-026 Otherwise in EXEC, the counter SHALL increment.
REQ-027 Latency: accept at edge T, first EXEC cycle follows, rsp_valid_o SHALL rise N+1 cycles after T.
REQ-028 rsp_valid_o SHALL be high only in RESP.
REQ-029 rsp_result_o and rsp_cmp_o SHALL stay stable while rsp_valid_o is high and rsp_ready_i is low.
REQ-030 In RESP, rsp_ready_i with req_valid_i SHALL hand off and accept in the same cycle, entering EXEC with no IDLE bubble.
REQ-031 In RESP, rsp_ready_i without req_valid_i SHALL return to IDLE.
REQ-032 flush_i in any state SHALL force IDLE next cycle, drop any pending response, block acceptance and leave the imd registers unchanged.
REQ-033 The ALU operand outputs SHALL hold their last latched values in IDLE.

Reset
REQ-034 Reset SHALL force IDLE with the counter at 0.
REQ-035 Reset SHALL clear to 0: req_ready_o after reset (IDLE, so 1), rsp_valid_o, busy_o, rsp_result_o, rsp_cmp_o, alu_instr_first_cycle_o, alu_operand_a_o, alu_operand_b_o and both imd registers.
REQ-036 Reset SHALL set alu_operator_o to ALU_ADD.
REQ-037 Reset asserted mid-EXEC SHALL abandon the operation; no response SHALL be produced after deassertion.

Structure
REQ-038 The state enum and the function returning the operator cycle count (given op and RV32B) SHALL reside in ibex_pkg.
REQ-039 The block SHALL instantiate no sub-module; it connects externally to ibex_alu.

Verification
REQ-040 ALU_AND, a=32'hFFFFFF00, b=32'h00FFFFFF, rsp_ready_i=1 -> rsp_valid_o 2 cycles after accept, rsp_result_o=32'h00FFFF00, first_cycle high for one cycle.
REQ-041 RV32B=RV32BFull, ALU_CMOV -> first_cycle pulses once, two EXEC cycles, imd writes captured, rsp_valid_o 3 cycles after accept.
REQ-042 rsp_ready_i held low 5 cycles -> rsp_valid_o stays high, result stable, req_ready_o low throughout.
REQ-043 Back-to-back ALU_ADD 1+2 then 3+4 with rsp_ready_i=1 -> results 3 and 7 on consecutive 2-cycle spacing, no bubble.
REQ-044 flush_i in the second cycle of a 2-cycle op -> IDLE next cycle, no rsp_valid_o, imd registers unchanged.
REQ-045 rst_ni low mid-EXEC -> all outputs at reset values asynchronously; no response after release.
